max7219_msg_font_loader: RTL and testbench

Upstream feeder for max7219_scroller_ctrl. Accepts an ASCII message one character at a time, expands each character into column bytes from an internal 5x7 font ROM, and writes them into the scroller RAM through its me/we/addr/wdata port. On completion it reports the byte length for i_msg_length and a done pulse. Optionally it pulses i_start_scroll.

---
 rtl/max7219_msg_font_loader.sv | 160 ++++++++++++++++
 tb/tb_max7219_msg_font_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/max7219_msg_font_loader.sv
// max7219_msg_font_loader: expands an ASCII message through a 5x7 font ROM into scroller RAM writes.
// Optional auto-start pulse on o_start_scroll enabled by MAX7219_LOADER_AUTO_START_EN.
module max7219_msg_font_loader #(
  parameter int G_RAM_ADDR_WIDTH = 8,
  parameter int G_RAM_DATA_WIDTH = 8,
  parameter int G_CHAR_WIDTH     = 6,
  parameter int G_MAX_BYTES      = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_ram_start_ptr,
  input  logic                        i_char_valid,
  input  logic [7:0]                  i_char,
  input  logic                        i_char_last,
  output logic                        o_char_ready,
  output logic                        o_me,
  output logic                        o_we,
  output logic [G_RAM_ADDR_WIDTH-1:0] o_addr,
  output logic [G_RAM_DATA_WIDTH-1:0] o_wdata,
  output logic [7:0]                  o_msg_length,
  output logic                        o_overflow,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_start_scroll
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_CHAR, S_WRITE, S_DONE} t_state;
  t_state r_state, w_next;
  logic [G_RAM_ADDR_WIDTH-1:0] r_base, r_addr;
  logic [G_RAM_DATA_WIDTH-1:0] r_wdata;
  logic [7:0] r_cnt, r_char, r_msg_length;
  logic [3:0] r_col;
  logic r_last, r_overflow, r_me;
  logic w_hs, w_fit, w_col_end, w_load;

  // Column 0 sits in the top byte; columns past the fifth shift out to 0x00.
  function automatic logic [7:0] f_glyph(input logic [7:0] i_c, input logic [3:0] i_col);
    logic [7:0]  c;
    logic [39:0] g, s;
    c = (i_c >= 8'h61 && i_c <= 8'h7A) ? i_c - 8'h20 : i_c;
    case (c)
      8'h20: g = 40'h0000000000;
      8'h2D: g = 40'h0808080808;
      8'h2E: g = 40'h0060600000;
      8'h30: g = 40'h3E5149453E;
      8'h31: g = 40'h00427F4000;
      8'h32: g = 40'h4261514946;
      8'h33: g = 40'h2141454B31;
      8'h34: g = 40'h1814127F10;
      8'h35: g = 40'h2745454539;
      8'h36: g = 40'h3C4A494930;
      8'h37: g = 40'h0171090503;
      8'h38: g = 40'h3649494936;
      8'h39: g = 40'h064949291E;
      8'h41: g = 40'h7E1111117E;
      8'h42: g = 40'h7F49494936;
      8'h43: g = 40'h3E41414122;
      8'h44: g = 40'h7F4141221C;
      8'h45: g = 40'h7F49494941;
      8'h46: g = 40'h7F09090901;
      8'h47: g = 40'h3E4149497A;
      8'h48: g = 40'h7F0808087F;
      8'h49: g = 40'h00417F4100;
      8'h4A: g = 40'h2040413F01;
      8'h4B: g = 40'h7F08142241;
      8'h4C: g = 40'h7F40404040;
      8'h4D: g = 40'h7F020C027F;
      8'h4E: g = 40'h7F0408107F;
      8'h4F: g = 40'h3E4141413E;
      8'h50: g = 40'h7F09090906;
      8'h51: g = 40'h3E4151215E;
      8'h52: g = 40'h7F09192946;
      8'h53: g = 40'h4649494931;
      8'h54: g = 40'h01017F0101;
      8'h55: g = 40'h3F4040403F;
      8'h56: g = 40'h1F2040201F;
      8'h57: g = 40'h3F4038403F;
      8'h58: g = 40'h6314081463;
      8'h59: g = 40'h0708700807;
      8'h5A: g = 40'h6151494543;
      default: g = 40'h7F7F7F7F7F;
    endcase
    s = g << (8 * i_col);
    return s[39:32];
  endfunction

  assign w_hs      = (r_state == S_WAIT_CHAR) && i_char_valid;
  assign w_fit     = int'(r_cnt) + G_CHAR_WIDTH <= G_MAX_BYTES;
  assign w_col_end = r_col == 4'(G_CHAR_WIDTH);
  assign w_load    = (w_hs && w_fit) || (r_state == S_WRITE && !w_col_end);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = i_start ? S_WAIT_CHAR : S_IDLE;
      S_WAIT_CHAR: w_next = !w_hs ? S_WAIT_CHAR : w_fit ? S_WRITE : i_char_last ? S_DONE : S_WAIT_CHAR;
      S_WRITE:     w_next = !w_col_end ? S_WRITE : r_last ? S_DONE : S_WAIT_CHAR;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;

  // Column 0 is loaded straight from i_char on the handshake so writes start the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_char       <= '0;
      r_col        <= '0;
      r_last       <= 1'b0;
      r_overflow   <= 1'b0;
      r_me         <= 1'b0;
      r_msg_length <= '0;
    end else begin
      r_me <= w_load;
      if (r_state == S_IDLE && i_start) begin
        r_base     <= i_ram_start_ptr;
        r_cnt      <= '0;
        r_overflow <= 1'b0;
      end
      if (w_hs) begin
        r_char <= i_char;
        r_last <= i_char_last;
        if (!w_fit) r_overflow <= 1'b1;
      end
      if (w_load) begin
        r_addr  <= r_base + G_RAM_ADDR_WIDTH'(r_cnt);
        r_wdata <= G_RAM_DATA_WIDTH'(f_glyph(w_hs ? i_char : r_char, w_hs ? 4'd0 : r_col));
        r_col   <= w_hs ? 4'd1 : r_col + 4'd1;
        r_cnt   <= r_cnt + 8'd1;
      end
      if (w_next == S_DONE) r_msg_length <= r_cnt;
    end
  end

`ifdef MAX7219_LOADER_AUTO_START_EN
  logic r_start_scroll;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_start_scroll <= 1'b0;
    else r_start_scroll <= (r_state == S_DONE) && (r_msg_length != 8'd0);
  assign o_start_scroll = r_start_scroll;
`else
  assign o_start_scroll = 1'b0;
`endif

  assign o_char_ready = r_state == S_WAIT_CHAR;
  assign o_busy       = r_state != S_IDLE;
  assign o_done       = r_state == S_DONE;
  assign o_me         = r_me;
  assign o_we         = r_me;
  assign o_addr       = r_addr;
  assign o_wdata      = r_wdata;
  assign o_msg_length = r_msg_length;
  assign o_overflow   = r_overflow;
endmodule

// File: tb/tb_max7219_msg_font_loader.sv
// tb_max7219_msg_font_loader: directed checks of the font loader, including a 12-byte capacity instance.
module tb_max7219_msg_font_loader;
  logic clk = 1'b0, rst = 1'b1;
  logic i_start = 1'b0, i_char_valid = 1'b0, i_char_last = 1'b0;
  logic [7:0] i_ram_start_ptr = '0, i_char = '0;
  logic m_rdy[2], m_me[2], m_we[2], m_ovf[2], m_busy[2], m_done[2], m_ss[2];
  logic [7:0] m_addr[2], m_wdata[2], m_len[2];
  logic [7:0] wa[2][64], wd[2][64];
  int nw[2], nd[2], nss[2], done_cyc[2], ss_cyc[2], rdy_bad[2];
  logic [7:0] len_at_done[2];
  int cyc = 0, n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  max7219_msg_font_loader u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_ram_start_ptr(i_ram_start_ptr),
    .i_char_valid(i_char_valid), .i_char(i_char), .i_char_last(i_char_last),
    .o_char_ready(m_rdy[0]), .o_me(m_me[0]), .o_we(m_we[0]), .o_addr(m_addr[0]),
    .o_wdata(m_wdata[0]), .o_msg_length(m_len[0]), .o_overflow(m_ovf[0]),
    .o_busy(m_busy[0]), .o_done(m_done[0]), .o_start_scroll(m_ss[0]));

  max7219_msg_font_loader #(.G_MAX_BYTES(12)) u_small (
    .clk(clk), .rst(rst), .i_start(i_start), .i_ram_start_ptr(i_ram_start_ptr),
    .i_char_valid(i_char_valid), .i_char(i_char), .i_char_last(i_char_last),
    .o_char_ready(m_rdy[1]), .o_me(m_me[1]), .o_we(m_we[1]), .o_addr(m_addr[1]),
    .o_wdata(m_wdata[1]), .o_msg_length(m_len[1]), .o_overflow(m_ovf[1]),
    .o_busy(m_busy[1]), .o_done(m_done[1]), .o_start_scroll(m_ss[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (m_me[k] || m_we[k]) begin
        if (nw[k] < 64) begin
          wa[k][nw[k]] = m_addr[k];
          wd[k][nw[k]] = m_wdata[k];
        end
        nw[k]++;
        if (m_rdy[k] || (m_me[k] != m_we[k])) rdy_bad[k]++;
      end
      if (m_done[k]) begin
        nd[k]++;
        done_cyc[k] = cyc;
        len_at_done[k] = m_len[k];
      end
      if (m_ss[k]) begin
        nss[k]++;
        ss_cyc[k] = cyc;
      end
    end
  end

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      nw[k] = 0; nd[k] = 0; nss[k] = 0; rdy_bad[k] = 0; done_cyc[k] = 0; ss_cyc[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A decoy 'Z' rides along with i_start; it must not be taken.
  task automatic send_msg(input logic [7:0] ptr, input string s, input int gap, input bit poke);
    clr();
    tick();
    i_start = 1'b1; i_ram_start_ptr = ptr; i_char_valid = 1'b1; i_char = 8'h5A; i_char_last = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      int t = 0;
      i_char_valid = 1'b1; i_char = s[i]; i_char_last = (i == s.len() - 1);
      while (!m_rdy[0] && t < 100) begin tick(); t++; end
      if (t >= 100) chk("ready_timeout", 1, 0);
      tick();
      i_char_valid = 1'b0;
      if (poke) begin
        i_start = 1'b1; i_ram_start_ptr = ptr ^ 8'h80;
        tick();
        i_start = 1'b0;
      end
      repeat (gap) tick();
    end
    repeat (12) tick();
  endtask

  task automatic chk_wr(input int k, input logic [7:0] base, input int n, input logic [143:0] e);
    chk("n_writes", nw[k], n);
    for (int i = 0; i < n && i < nw[k] && i < 18; i++) begin
      logic [7:0] a;
      a = base + 8'(i);
      chk($sformatf("addr%0d", i), wa[k][i], a);
      chk($sformatf("data%0d", i), wd[k][i], e[143-8*i -: 8]);
    end
  endtask

  initial begin
    clr();
    repeat (3) tick();
    chk("rst_me", m_me[0], 0);
    chk("rst_we", m_we[0], 0);
    chk("rst_busy", m_busy[0], 0);
    chk("rst_done", m_done[0], 0);
    chk("rst_ready", m_rdy[0], 0);
    chk("rst_len", m_len[0], 0);
    chk("rst_ovf", m_ovf[0], 0);
    chk("rst_ss", m_ss[0], 0);
    rst = 1'b0;
    tick();

    send_msg(8'h10, "A", 0, 0);
    chk_wr(0, 8'h10, 6, {48'h7E1111117E00, 96'h0});
    chk("t1_done", nd[0], 1);
    chk("t1_len_at_done", len_at_done[0], 6);
    chk("t1_len", m_len[0], 6);
    chk("t1_ovf", m_ovf[0], 0);
    chk("t1_busy", m_busy[0], 0);

    send_msg(8'h20, "a-?", 3, 0);
    chk_wr(0, 8'h20, 18, 144'h7E1111117E00_080808080800_7F7F7F7F7F00);
    chk("t2_ready_in_write", rdy_bad[0], 0);
    chk("t2_done", nd[0], 1);
    chk("t2_len", m_len[0], 18);

    send_msg(8'hFE, "1 ", 0, 0);
    chk_wr(0, 8'hFE, 12, {96'h00427F400000_000000000000, 48'h0});
    chk("t3_len", m_len[0], 12);

    send_msg(8'h00, "ABC", 0, 0);
    chk_wr(1, 8'h00, 12, {96'h7E1111117E00_7F4949493600, 48'h0});
    chk("t4_ovf", m_ovf[1], 1);
    chk("t4_len", m_len[1], 12);
    chk("t4_done", nd[1], 1);
    chk("t4_main_ovf", m_ovf[0], 0);
    chk("t4_main_len", m_len[0], 18);

    clr();
    tick();
    i_start = 1'b1; i_ram_start_ptr = 8'h30;
    tick();
    i_start = 1'b0; i_char_valid = 1'b1; i_char = 8'h41; i_char_last = 1'b1;
    tick();
    i_char_valid = 1'b0;
    tick();
    tick();
    chk("t5_me_before", m_me[0], 1);
    rst = 1'b1;
    #1;
    chk("t5_me", m_me[0], 0);
    chk("t5_we", m_we[0], 0);
    chk("t5_busy", m_busy[0], 0);
    chk("t5_len", m_len[0], 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("t5_writes", nw[0], 2);
    chk("t5_done", nd[0], 0);

    send_msg(8'h40, "A", 0, 1);
    chk_wr(0, 8'h40, 6, {48'h7E1111117E00, 96'h0});
    chk("t5_restart_len", m_len[0], 6);

    send_msg(8'h50, "8", 0, 0);
    chk_wr(0, 8'h50, 6, {48'h364949493600, 96'h0});
`ifdef MAX7219_LOADER_AUTO_START_EN
    chk("t6_ss_count", nss[0], 1);
    chk("t6_ss_cycle", ss_cyc[0], done_cyc[0] + 1);
`else
    chk("t6_ss_count", nss[0], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
